// File: rtl/ssp_min_select_pkg.sv
// Shared definitions for the SSSP extract-min datapath.
// Holds the distance RAM entry layout (distance field, visited flag), the
// INF sentinel, the extract-min FSM state encoding and entry field helpers.
package ssp_min_select_pkg;

    localparam int ENTRY_W = 64;
    localparam int DIST_W  = 32;
    localparam int VIS_BIT = 32;

    localparam logic [DIST_W-1:0] INF = '1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        MARK,
        DONE
    } state_t;

    function automatic logic [DIST_W-1:0] ent_dist(input logic [ENTRY_W-1:0] e);
        return e[DIST_W-1:0];
    endfunction

    function automatic logic ent_vis(input logic [ENTRY_W-1:0] e);
        return e[VIS_BIT];
    endfunction

    // Unvisited and reachable.
    function automatic logic ent_eligible(input logic [ENTRY_W-1:0] e);
        return !ent_vis(e) && (ent_dist(e) != INF);
    endfunction

    // Same entry with the visited flag raised; distance is untouched.
    function automatic logic [ENTRY_W-1:0] ent_mark(input logic [ENTRY_W-1:0] e);
        logic [ENTRY_W-1:0] r;
        r          = e;
        r[VIS_BIT] = 1'b1;
        return r;
    endfunction

    // Result word handed downstream: zero-padded distance, visited reads 0.
    function automatic logic [ENTRY_W-1:0] ent_result(input logic [DIST_W-1:0] d);
        return ENTRY_W'(d);
    endfunction

endpackage

// File: rtl/ssp_min_select_if.sv
// Bundle of the extract-min request/result signals and the distance RAM port.
// slave  : the extract-min block's view.
// master : the controller / RAM side (testbench).
interface ssp_min_select_if
    import ssp_min_select_pkg::*;
#(
    parameter int ADDR_W = 10
) ();
    logic               start;
    logic [31:0]        numof_nodes;
    logic               busy;
    logic               done;
    logic               found;
    logic [ADDR_W-1:0]  min_node;
    logic [ENTRY_W-1:0] distance_of_minimum;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ENTRY_W-1:0] rd_data;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ENTRY_W-1:0] wr_data;

    modport slave (
        input  start, numof_nodes, rd_data,
        output busy, done, found, min_node, distance_of_minimum,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport master (
        output start, numof_nodes, rd_data,
        input  busy, done, found, min_node, distance_of_minimum,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/ssp_min_select_cmp.sv
// Candidate update for extract-min.
// Inputs : one tagged read beat (valid, address, entry) and the current
//          candidate (valid, address, stored entry).
// Outputs: the next candidate. A beat wins only if it is eligible and its
//          distance is strictly below the candidate's, so ties keep the
//          lower address that arrived first.
module ssp_min_select_cmp
    import ssp_min_select_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               beat_vld,
    input  logic [ADDR_W-1:0]  beat_addr,
    input  logic [ENTRY_W-1:0] beat_data,
    input  logic               cand_vld,
    input  logic [ADDR_W-1:0]  cand_addr,
    input  logic [ENTRY_W-1:0] cand_entry,
    output logic               nxt_vld,
    output logic [ADDR_W-1:0]  nxt_addr,
    output logic [ENTRY_W-1:0] nxt_entry
);
    logic take;

    // An invalid candidate carries INF, so any eligible beat beats it.
    assign take = beat_vld && ent_eligible(beat_data)
               && (ent_dist(beat_data) < ent_dist(cand_entry));

    assign nxt_vld   = take ? 1'b1      : cand_vld;
    assign nxt_addr  = take ? beat_addr : cand_addr;
    assign nxt_entry = take ? beat_data : cand_entry;
endmodule

// File: rtl/ssp_min_select.sv
// Extract-min stage of the SSSP accelerator.
// On start, reads entries 0..N-1 of the distance RAM, keeps the unvisited
// node with the smallest finite distance, writes its visited flag back and
// reports it (found / min_node / distance_of_minimum) with a done pulse.
// Ports: clk, rstn (async, active low) and the slave side of
// ssp_min_select_if (start/numof_nodes request, busy/done/result outputs,
// distance RAM read and write ports).
module ssp_min_select
    import ssp_min_select_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic clk,
    input  logic rstn,
    ssp_min_select_if.slave bus
);
    localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    state_t             state, state_nxt;
    // One bit wider than an address so N = 2**ADDR_W is representable.
    logic [ADDR_W:0]    cnt, n_reg, n_clamp;

    // Read-side tag: rd_en/rd_addr delayed to line up with rd_data.
    logic               rd_vld_q;
    logic [ADDR_W-1:0]  rd_addr_q;

    logic               cand_vld, nxt_vld;
    logic [ADDR_W-1:0]  cand_addr, nxt_addr;
    logic [ENTRY_W-1:0] cand_entry, nxt_entry;

    logic               res_found;
    logic [ADDR_W-1:0]  res_node;
    logic [ENTRY_W-1:0] res_dist;

    logic               accept;

    assign n_clamp = (bus.numof_nodes > 32'(MAX_N)) ? MAX_N : bus.numof_nodes[ADDR_W:0];
    assign accept  = (state == IDLE) && bus.start;

    ssp_min_select_cmp #(.ADDR_W(ADDR_W)) u_cmp (
        .beat_vld   (rd_vld_q),
        .beat_addr  (rd_addr_q),
        .beat_data  (bus.rd_data),
        .cand_vld   (cand_vld),
        .cand_addr  (cand_addr),
        .cand_entry (cand_entry),
        .nxt_vld    (nxt_vld),
        .nxt_addr   (nxt_addr),
        .nxt_entry  (nxt_entry)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            n_reg      <= '0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            cand_vld   <= 1'b0;
            cand_addr  <= '0;
            cand_entry <= ent_result(INF);
            res_found  <= 1'b0;
            res_node   <= '0;
            res_dist   <= '0;
        end else begin
            state     <= state_nxt;
            rd_vld_q  <= bus.rd_en;
            rd_addr_q <= bus.rd_addr;

            if (accept) begin
                cnt        <= '0;
                n_reg      <= n_clamp;
                cand_vld   <= 1'b0;
                cand_addr  <= '0;
                cand_entry <= ent_result(INF);
            end else begin
                cand_vld   <= nxt_vld;
                cand_addr  <= nxt_addr;
                cand_entry <= nxt_entry;
            end

            if (state == SCAN)
                cnt <= cnt + ONE;

            // Results are loaded on entry to DONE so they are valid with done.
            if (accept && (n_clamp == '0)) begin
                res_found <= 1'b0;
                res_node  <= '0;
                res_dist  <= '0;
            end else if (state == MARK) begin
                res_found <= cand_vld;
                res_node  <= cand_addr;
                res_dist  <= cand_vld ? ent_result(ent_dist(cand_entry)) : '0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = (n_clamp == '0) ? DONE : SCAN;
            end
            SCAN: begin
                bus.busy    = 1'b1;
                bus.rd_en   = 1'b1;
                bus.rd_addr = cnt[ADDR_W-1:0];
                if (cnt == n_reg - ONE)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                bus.busy  = 1'b1;
                state_nxt = MARK;
            end
            MARK: begin
                bus.busy = 1'b1;
                if (cand_vld) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = cand_addr;
                    bus.wr_data = ent_mark(cand_entry);
                end
                state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.found               = res_found;
    assign bus.min_node            = res_node;
    assign bus.distance_of_minimum = res_dist;
endmodule

// File: tb/tb_ssp_min_select.sv
module tb_ssp_min_select;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam logic [63:0] VIS  = 64'h1_0000_0000;
    localparam logic [63:0] INFE = 64'h0_FFFF_FFFF;

    logic clk;
    logic rstn;

    ssp_min_select_if #(.ADDR_W(AW)) bus ();

    ssp_min_select #(.ADDR_W(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Distance RAM model: 1-cycle read latency, write on wr_en, plus a
    // bench-side load port (1 = single put, 2 = fill every entry).
    logic [63:0]   mem [0:DEPTH-1];
    logic [1:0]    ld_op;
    logic [AW-1:0] ld_a;
    logic [63:0]   ld_d;

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        if (ld_op == 2'd1) mem[ld_a] <= ld_d;
        if (ld_op == 2'd2) for (int i = 0; i < DEPTH; i++) mem[i] <= ld_d;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic mem_put(input logic [AW-1:0] a, input logic [63:0] d);
        @(negedge clk);
        ld_op = 2'd1; ld_a = a; ld_d = d;
        @(posedge clk); #1 ld_op = 2'd0;
    endtask

    task automatic mem_fill(input logic [63:0] d);
        @(negedge clk);
        ld_op = 2'd2; ld_d = d;
        @(posedge clk); #1 ld_op = 2'd0;
    endtask

    // Results of the last run: latency in cycles after the start cycle,
    // read/write pulse counts and the last write seen.
    int          r_lat, r_rd, r_wr;
    logic [AW-1:0] r_waddr;
    logic [63:0] r_wdata;

    // Issue start with N; optionally re-pulse start at cycle extra_at.
    task automatic run(input logic [31:0] n, input int extra_at);
        int  k;
        bit  seen;
        @(negedge clk);
        bus.numof_nodes = n;
        bus.start = 1'b1;
        k = 0; seen = 0;
        r_lat = -1; r_rd = 0; r_wr = 0; r_waddr = '0; r_wdata = '0;
        while (k < 3000 && !seen) begin
            @(negedge clk);
            k++;
            bus.start = (k == extra_at);
            if (bus.rd_en) r_rd++;
            if (bus.wr_en) begin
                r_wr++;
                r_waddr = bus.wr_addr;
                r_wdata = bus.wr_data;
            end
            if (bus.done) begin
                seen  = 1;
                r_lat = k;
            end
        end
        if (!seen) chk("done_timeout", 64'(seen), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    int          idle_rd;
    int          hits [0:4];
    int          rst_wr;
    int          exp_node [0:3];
    int          exp_dist [0:3];
    int          exp_hits [0:4];

    initial begin
        rstn = 1'b0;
        bus.start = 1'b0;
        bus.numof_nodes = '0;
        ld_op = 2'd0; ld_a = '0; ld_d = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ctl", {59'd0, bus.busy, bus.done, bus.found, bus.rd_en, bus.wr_en}, 64'd0);
        chk("rst_node", 64'(bus.min_node), 64'd0);
        chk("rst_dist", bus.distance_of_minimum, 64'd0);
        rstn = 1'b1;

        // N=4 with a tie at distance 3 and a visited smaller entry
        mem_fill(INFE);
        mem_put(0, 64'd5); mem_put(1, 64'd3); mem_put(2, 64'd3); mem_put(3, VIS | 64'd1);
        run(4, 0);
        chk("a_lat", 64'(r_lat), 64'd7);
        chk("a_rd", 64'(r_rd), 64'd4);
        chk("a_wr", 64'(r_wr), 64'd1);
        chk("a_waddr", 64'(r_waddr), 64'd1);
        chk("a_wdata", r_wdata, 64'h1_0000_0003);
        chk("a_found", 64'(bus.found), 64'd1);
        chk("a_node", 64'(bus.min_node), 64'd1);
        chk("a_dist", bus.distance_of_minimum, 64'd3);
        repeat (3) @(negedge clk);
        chk("a_hold", {bus.found, 7'd0, bus.distance_of_minimum[55:0]}, {1'b1, 63'd3});
        chk("a_mem1", mem[1], 64'h1_0000_0003);

        // N=3, nothing eligible
        mem_put(0, VIS | 64'd2); mem_put(1, INFE); mem_put(2, VIS | INFE);
        run(3, 0);
        chk("b_lat", 64'(r_lat), 64'd6);
        chk("b_wr", 64'(r_wr), 64'd0);
        chk("b_found", 64'(bus.found), 64'd0);
        chk("b_node", 64'(bus.min_node), 64'd0);

        // N=0
        run(0, 0);
        chk("c_lat", 64'(r_lat), 64'd1);
        chk("c_rd", 64'(r_rd), 64'd0);
        chk("c_found", 64'(bus.found), 64'd0);

        // start re-pulsed mid-SCAN, then start coinciding with done
        mem_fill(INFE);
        mem_put(0, 64'd9); mem_put(1, 64'd4); mem_put(2, 64'd4); mem_put(3, 64'd8);
        run(4, 2);
        chk("d_lat", 64'(r_lat), 64'd7);
        chk("d_rd", 64'(r_rd), 64'd4);
        chk("d_node", 64'(bus.min_node), 64'd1);
        run(4, 7);
        chk("d2_node", 64'(bus.min_node), 64'd2);
        chk("d2_dist", bus.distance_of_minimum, 64'd4);
        idle_rd = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rd_en || bus.busy) idle_rd++;
        end
        chk("d2_no_rerun", 64'(idle_rd), 64'd0);

        // Reset dropped mid-SCAN
        @(negedge clk);
        bus.numof_nodes = 4; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("e_scanning", 64'(bus.rd_en), 64'd1);
        rstn = 1'b0;
        #1;
        chk("e_rst_ctl", {60'd0, bus.busy, bus.found, bus.rd_en, bus.wr_en}, 64'd0);
        chk("e_rst_res", {bus.distance_of_minimum[53:0], bus.min_node}, 64'd0);
        rst_wr = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.wr_en) rst_wr++;
        end
        rstn = 1'b1;
        chk("e_no_wr", 64'(rst_wr), 64'd0);
        chk("e_mem3", mem[3], 64'd8);
        run(4, 0);
        chk("e_lat", 64'(r_lat), 64'd7);
        chk("e_node", 64'(bus.min_node), 64'd3);
        chk("e_wdata", r_wdata, 64'h1_0000_0008);

        // Full address range, single eligible node at the top
        mem_fill(INFE);
        mem_put(DEPTH - 1, 64'd7);
        run(DEPTH, 0);
        chk("f_lat", 64'(r_lat), 64'(DEPTH + 3));
        chk("f_rd", 64'(r_rd), 64'(DEPTH));
        chk("f_node", 64'(bus.min_node), 64'(DEPTH - 1));
        chk("f_dist", bus.distance_of_minimum, 64'd7);
        chk("f_waddr", 64'(r_waddr), 64'(DEPTH - 1));
        // Oversized N clamps to the full range
        run(32'hFFFF_FFFF, 0);
        chk("f2_rd", 64'(r_rd), 64'(DEPTH));
        chk("f2_found", 64'(bus.found), 64'd0);

        // 5-node graph drained by repeated extract-min
        mem_fill(INFE);
        mem_put(0, 64'd7); mem_put(1, 64'd2); mem_put(2, INFE); mem_put(3, 64'd5); mem_put(4, 64'd2);
        exp_node = '{1, 4, 3, 0};
        exp_dist = '{2, 2, 5, 7};
        exp_hits = '{1, 1, 0, 1, 1};
        hits = '{0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            run(5, 0);
            chk($sformatf("g_found%0d", i), 64'(bus.found), 64'd1);
            chk($sformatf("g_node%0d", i), 64'(bus.min_node), 64'(exp_node[i]));
            chk($sformatf("g_dist%0d", i), bus.distance_of_minimum, 64'(exp_dist[i]));
            if (r_wr == 1 && r_waddr < 5) hits[r_waddr]++;
        end
        run(5, 0);
        chk("g_end_found", 64'(bus.found), 64'd0);
        chk("g_end_wr", 64'(r_wr), 64'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("g_hits%0d", i), 64'(hits[i]), 64'(exp_hits[i]));
            chk($sformatf("g_vis%0d", i), 64'(mem[i][32]), 64'(exp_hits[i]));
        end
        chk("g_mem3", mem[3], 64'h1_0000_0005);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
